// File: rtl/sample_gather.sv
// sample_gather: packs groups of eight signed samples from a valid/ready
// stream into a registered, double-buffered frame a..h for the averager.
// An optional partial-frame flush is compiled in when GATHER_FLUSH_EN is defined.
module sample_gather #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned SHAMT     = 1
) (
  input  logic                 Clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] c,
  output logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] e,
  output logic [DATAWIDTH-1:0] f,
  output logic [DATAWIDTH-1:0] g,
  output logic [DATAWIDTH-1:0] h,
  output logic                 frame_valid,
  input  logic                 frame_ack,
  output logic [7:0]           sa
`ifdef GATHER_FLUSH_EN
  ,
  input  logic                 flush
`endif
);

  localparam int unsigned NSLOT = 8;

  typedef enum logic {S_FILL, S_HOLD} state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] slot_q [NSLOT];
  logic [DATAWIDTH-1:0] slot_d [NSLOT];
  logic [DATAWIDTH-1:0] bank_q [NSLOT];
  logic [DATAWIDTH-1:0] bank_d [NSLOT];
  logic                 fv_q, fv_d;
  logic                 bank_free;
  logic                 accept;
`ifdef GATHER_FLUSH_EN
  logic                 pend_q, pend_d;
`endif

  // Bank can take a new frame when empty or being acknowledged this cycle.
  assign bank_free = !fv_q || frame_ack;
  assign accept    = in_valid && in_ready;

  // Ready depends on state (and reset) only; a pending flush also stalls input.
`ifdef GATHER_FLUSH_EN
  assign in_ready = !rst && (state_q == S_FILL) && !pend_q;
`else
  assign in_ready = !rst && (state_q == S_FILL);
`endif

  assign sa          = 8'(SHAMT);
  assign frame_valid = fv_q;
  assign a = bank_q[0];
  assign b = bank_q[1];
  assign c = bank_q[2];
  assign d = bank_q[3];
  assign e = bank_q[4];
  assign f = bank_q[5];
  assign g = bank_q[6];
  assign h = bank_q[7];

  // Next-state: fill slots, load the bank on a full group, hold while bank busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    bank_d  = bank_q;
    fv_d    = fv_q && !frame_ack;
`ifdef GATHER_FLUSH_EN
    pend_d  = pend_q;
`endif
    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          slot_d[cnt_q] = in_data;
          cnt_d         = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (bank_free) begin
              for (int i = 0; i < NSLOT - 1; i++) bank_d[i] = slot_q[i];
              bank_d[NSLOT-1] = in_data;
              fv_d            = 1'b1;
            end else begin
              state_d = S_HOLD;
            end
          end
        end
`ifdef GATHER_FLUSH_EN
        // A completed group supersedes a flush; otherwise emit or defer a partial frame.
        if ((flush || pend_q) && !(accept && cnt_q == 3'd7) &&
            (cnt_q != 3'd0 || accept)) begin
          if (bank_free) begin
            for (int i = 0; i < NSLOT; i++) begin
              if (3'(i) < cnt_q)                  bank_d[i] = slot_q[i];
              else if (accept && 3'(i) == cnt_q)  bank_d[i] = in_data;
              else                                bank_d[i] = '0;
            end
            fv_d   = 1'b1;
            cnt_d  = 3'd0;
            pend_d = 1'b0;
          end else begin
            pend_d = 1'b1;
          end
        end
`endif
      end
      S_HOLD: begin
        if (bank_free) begin
          bank_d  = slot_q;
          fv_d    = 1'b1;
          state_d = S_FILL;
        end
      end
    endcase
  end

  // State, fill buffer and output bank registers.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      cnt_q   <= 3'd0;
      fv_q    <= 1'b0;
`ifdef GATHER_FLUSH_EN
      pend_q  <= 1'b0;
`endif
      for (int i = 0; i < NSLOT; i++) begin
        slot_q[i] <= '0;
        bank_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
`ifdef GATHER_FLUSH_EN
      pend_q  <= pend_d;
`endif
      for (int i = 0; i < NSLOT; i++) begin
        slot_q[i] <= slot_d[i];
        bank_q[i] <= bank_d[i];
      end
    end
  end

endmodule

// File: doc/sample_gather.md
# sample_gather

Stream-to-parallel front end for the 8-input averaging datapath. Accepts signed 16-bit samples one at a time on a valid/ready handshake and packs each group of eight into a registered output frame `a`..`h`. Asserts `frame_valid` until the consumer returns `frame_ack`. Also drives the shift amount `sa` for the averager's shift stages. A fill buffer plus an output bank give double buffering: a new group can be collected while the previous frame waits for acknowledgement.

## Interface
- `DATAWIDTH`, 16: sample and frame word width.
- `SHAMT`, 1: constant driven on `sa`; 1 gives /8 across three shift stages.
- `Clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `in_data`  in  DATAWIDTH  signed sample.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  block accepts a sample this cycle.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`,`h`  out  DATAWIDTH each  frame words, registered; `a` holds the first sample of the group, `h` the eighth.
- `frame_valid`  out  1  frame bank holds an unacknowledged frame.
- `frame_ack`  in  1  consumer takes the frame; ignored while `frame_valid`=0.
- `sa`  out  8  constant `SHAMT[7:0]`.
- `flush`  in  1  present only with `GATHER_FLUSH_EN`; see Configuration.

## Operation
- A sample is accepted on a rising edge with `in_valid & in_ready`. It is written to fill slot `cnt`, and `cnt` (3 bits) increments.
- States:
  - FILL: `in_ready`=1.
  - HOLD: all eight fill slots are full, but the bank is occupied; `in_ready`=0.
- Bank is free when `frame_valid`=0, or when `frame_ack`=1 in the same cycle.
- Eighth sample accepted (`cnt`=7):
  - If the bank is free: load the bank with slots 0..6 plus `in_data` into `h`, set `frame_valid`, set `cnt` to 0, stay in FILL.
  - Otherwise: store the sample in slot 7, set `cnt` to 0 (wraps), go to HOLD.
- HOLD: on the first edge where the bank is free, copy slots 0..7 to the bank, keep `frame_valid`=1, go to FILL.
- `frame_ack` with no new frame loaded on the same edge: `frame_valid` falls. Bank contents are retained, not cleared.
- `frame_ack` on the same edge as a bank load: the new frame replaces the old one and `frame_valid` stays 1. No bubble and no loss.
- Sample data is passed through unchanged; no arithmetic, no sign handling.
- Reset at any time:
  - `cnt`=0, state FILL, partial group discarded.
  - `frame_valid`=0, `a`..`h`=0, fill slots=0.
  - `in_ready`=0 while `rst` is high; 1 on the first cycle after release.
  - `sa`=`SHAMT` always, including during reset.

## Timing
- `in_ready` is combinational from state (and `rst`) only. It never depends on `in_valid`.
- Latency: the eighth sample accepted at edge N gives `frame_valid`=1 and valid `a`..`h` right after edge N (0 cycles) when the bank is free.
- From HOLD: frame loaded at the edge where the bank is free; `in_ready` returns to 1 in the following cycle.
- Sustained throughput: 1 sample/cycle when `frame_ack` is returned in the same cycle `frame_valid` rises.
- `frame_valid` and `a`..`h` are stable while `frame_valid`=1 and `frame_ack`=0.

## Configuration
- `GATHER_FLUSH_EN` defined:
  - `flush` port exists.
  - In FILL with `cnt`>0 and the bank free, `flush`=1 on an edge emits a partial frame: accepted slots, plus any sample accepted on that same edge; remaining words are 0; `frame_valid` is set and `cnt`=0.
  - If the bank is not free, the flush is held pending (and `in_ready`=0) until it is.
  - `flush` with `cnt`=0 and no sample accepted on that edge does nothing.
- Not defined: no `flush` port; frames are emitted only on complete groups of eight.

## Test plan
- Reset release, then samples 1..8 on consecutive cycles, `frame_ack` tied 1 → after the 8th edge, `a`..`h`=1..8 with `frame_valid` high for exactly 1 cycle; `sa`=1 throughout.
- Samples −1, −32768, 32767, 0, 5, −5, 100, −100 → `a`..`h` match bit-exactly (0xFFFF, 0x8000, 0x7FFF, …).
- 16 samples back-to-back with `frame_ack`=0 → first frame holds 1..8, `in_ready` falls after the 16th accept. Then pulse `frame_ack` one cycle → bank becomes 9..16 with `frame_valid` still 1, and `in_ready`=1 next cycle.
- `frame_ack` coincident with the 8th sample of the next group → frame replaced on the same edge, `frame_valid` never drops, no sample lost.
- Assert `rst` after 5 samples, then send 10..17 → frame is 10..17; `in_ready`=0 during reset.
- (`GATHER_FLUSH_EN`) 3 samples 7,8,9 then `flush` → frame 7,8,9,0,0,0,0,0; next group starts at `a`.
